// File: rtl/demux_1to4_dispatch_if.sv
// Handshake bundle between one producer and the four-lane dispatcher.
// The slave modport is the dispatcher's view; the master modport is the environment's view.
interface demux_1to4_dispatch_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] src;
  logic             src_valid;
  logic             src_ready;
  logic [1:0]       select;
  logic [WIDTH-1:0] dst1;
  logic [WIDTH-1:0] dst2;
  logic [WIDTH-1:0] dst3;
  logic [WIDTH-1:0] dst4;
  logic [3:0]       dst_valid;
  logic [3:0]       dst_ready;
  logic             busy;

  modport slave (
    input  src, src_valid, select, dst_ready,
    output src_ready, dst1, dst2, dst3, dst4, dst_valid, busy
  );

  modport master (
    output src, src_valid, select, dst_ready,
    input  src_ready, dst1, dst2, dst3, dst4, dst_valid, busy
  );
endinterface

// File: rtl/demux_1to4_dispatch.sv
// Registered 1-to-4 dispatcher: each lane is a 1-entry buffer with valid/ready handshake.
// Optional feature macro ROUND_ROBIN_EN: ignore select and target lanes from an internal pointer.
module demux_1to4_dispatch #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  demux_1to4_dispatch_if.slave   bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  lane_state_t      r_state     [4];
  lane_state_t      w_stateNext [4];
  logic [WIDTH-1:0] r_data      [4];
  logic [3:0]       w_load;
  logic [3:0]       w_valid;
  logic [1:0]       w_tgt;
  logic             w_srcReady;
  logic             w_accept;

`ifdef ROUND_ROBIN_EN
  logic [1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 2'd0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 2'd1;
    end
  end

  assign w_tgt = r_ptr;
`else
  assign w_tgt = bus.select;
`endif

  // A full target lane can still take a word when its consumer drains it this cycle.
  assign w_srcReady = (r_state[w_tgt] == EMPTY) | bus.dst_ready[w_tgt];
  assign w_accept   = bus.src_valid & w_srcReady;

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      w_stateNext[l] = r_state[l];
      w_load[l]      = 1'b0;
      if (w_accept && (w_tgt == 2'(l))) begin
        w_stateNext[l] = FULL;
        w_load[l]      = 1'b1;
      end else if ((r_state[l] == FULL) && bus.dst_ready[l]) begin
        w_stateNext[l] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < 4; l++) begin
        r_state[l] <= EMPTY;
        r_data[l]  <= '0;
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        r_state[l] <= w_stateNext[l];
        if (w_load[l]) begin
          r_data[l] <= bus.src;
        end
      end
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      w_valid[l] = (r_state[l] == FULL);
    end
  end

  assign bus.src_ready = w_srcReady;
  assign bus.dst1      = r_data[0];
  assign bus.dst2      = r_data[1];
  assign bus.dst3      = r_data[2];
  assign bus.dst4      = r_data[3];
  assign bus.dst_valid = w_valid;
  assign bus.busy      = |w_valid;

endmodule

// File: tb/tb_demux_1to4_dispatch.sv
// Bench for demux_1to4_dispatch: directed scenarios with literal expectations plus random traffic
// compared every cycle against a lane-buffer model (also honours ROUND_ROBIN_EN).
module tb_demux_1to4_dispatch;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;

  demux_1to4_dispatch_if #(.WIDTH(WIDTH)) bus ();

  demux_1to4_dispatch #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: what each consumer currently holds, plus the round-robin turn.
  logic [WIDTH-1:0] mData  [4];
  bit               mValid [4];
  int               mPtr   = 0;
  bit               mKnown = 1'b0;
  bit               lastStall = 1'b0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int modelTarget();
`ifdef ROUND_ROBIN_EN
    return mPtr;
`else
    return int'(bus.select);
`endif
  endfunction

  // Compares every visible output against the model for the inputs currently driven.
  task automatic checkOutput();
    int         tgt;
    logic       expReady;
    logic [3:0] expValid;
    if (!mKnown) return;
    tgt      = modelTarget();
    expReady = !mValid[tgt] || bus.dst_ready[tgt];
    for (int l = 0; l < 4; l++) expValid[l] = mValid[l];
    chk("src_ready", {31'd0, bus.src_ready}, {31'd0, expReady});
    chk("dst_valid", {28'd0, bus.dst_valid}, {28'd0, expValid});
    chk("busy", {31'd0, bus.busy}, {31'd0, (expValid != 4'd0)});
    chk("dst1", bus.dst1, mData[0]);
    chk("dst2", bus.dst2, mData[1]);
    chk("dst3", bus.dst3, mData[2]);
    chk("dst4", bus.dst4, mData[3]);
  endtask

  // Drives one cycle of inputs, checks, then advances the model across the rising edge.
  task automatic applyStimulus(input logic r, input logic sv, input logic [WIDTH-1:0] s,
                               input logic [1:0] sel, input logic [3:0] rdy);
    int tgt;
    bit acc;
    @(negedge clk);
    rst           = r;
    bus.src_valid = sv;
    bus.src       = s;
    bus.select    = sel;
    bus.dst_ready = rdy;
    #1;
    checkOutput();
    tgt = modelTarget();
    acc = mKnown && sv && (!mValid[tgt] || rdy[tgt]);
    lastStall = !r && mKnown && sv && !acc;
    @(posedge clk);
    if (r) begin
      for (int l = 0; l < 4; l++) begin
        mValid[l] = 1'b0;
        mData[l]  = '0;
      end
      mPtr   = 0;
      mKnown = 1'b1;
    end else if (mKnown) begin
      for (int l = 0; l < 4; l++) begin
        if (acc && tgt == l) begin
          mValid[l] = 1'b1;
          mData[l]  = s;
        end else if (rdy[l]) begin
          mValid[l] = 1'b0;
        end
      end
      if (acc) mPtr = (mPtr + 1) % 4;
    end
    #1;
  endtask

  logic [WIDTH-1:0] rS;
  logic             rV;
  logic [1:0]       rSel;
  logic [3:0]       rR;
  logic             rRst;

  initial begin
    rst           = 1'b1;
    bus.src_valid = 1'b0;
    bus.src       = '0;
    bus.select    = 2'b00;
    bus.dst_ready = 4'b0000;

    // Reset for two cycles.
    applyStimulus(1'b1, 1'b0, '0, 2'b00, 4'b0000);
    applyStimulus(1'b1, 1'b0, '0, 2'b00, 4'b0000);
    chk("rst dst_valid", {28'd0, bus.dst_valid}, 32'd0);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst dst1", bus.dst1, 32'd0);
    chk("rst dst4", bus.dst4, 32'd0);
    chk("rst src_ready", {31'd0, bus.src_ready}, 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 2'b00, 4'b0000);

`ifndef ROUND_ROBIN_EN
    applyStimulus(1'b0, 1'b1, 32'hA5A5_0001, 2'b10, 4'b0000);
    chk("single dst3", bus.dst3, 32'hA5A5_0001);
    chk("single dst_valid", {28'd0, bus.dst_valid}, 32'h4);
    applyStimulus(1'b0, 1'b0, '0, 2'b00, 4'b0000);

    applyStimulus(1'b0, 1'b1, 32'h10, 2'b00, 4'b0000);
    applyStimulus(1'b0, 1'b1, 32'h11, 2'b01, 4'b0000);
    applyStimulus(1'b0, 1'b1, 32'h13, 2'b11, 4'b0000);
    chk("fill dst_valid", {28'd0, bus.dst_valid}, 32'hF);
    applyStimulus(1'b0, 1'b1, 32'hBEEF_0002, 2'b01, 4'b0000);
    chk("stall src_ready", {31'd0, bus.src_ready}, 32'd0);
    chk("stall dst2", bus.dst2, 32'h11);
    applyStimulus(1'b0, 1'b1, 32'hBEEF_0002, 2'b01, 4'b0010);
    chk("replace dst2", bus.dst2, 32'hBEEF_0002);
    chk("replace dst_valid", {28'd0, bus.dst_valid}, 32'hF);

    applyStimulus(1'b0, 1'b1, 32'h1234, 2'b00, 4'b0001);
    chk("b2b dst_valid0", {31'd0, bus.dst_valid[0]}, 32'd1);
    chk("b2b dst1", bus.dst1, 32'h1234);
`endif

    // Fill every lane, then reset with a transfer offered: nothing may load.
    applyStimulus(1'b1, 1'b0, '0, 2'b00, 4'b0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'h20 + i, 2'(i), 4'b0000);
    chk("full busy", {31'd0, bus.busy}, 32'd1);
    chk("full dst4", bus.dst4, 32'h23);
    applyStimulus(1'b1, 1'b1, 32'hDEAD, 2'b00, 4'b0000);
    chk("midrst dst_valid", {28'd0, bus.dst_valid}, 32'd0);
    chk("midrst dst1", bus.dst1, 32'd0);

`ifdef ROUND_ROBIN_EN
    applyStimulus(1'b0, 1'b0, '0, 2'b00, 4'b0000);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, WIDTH'(i), 2'($urandom_range(0, 3)), 4'b1111);
    chk("rr dst1", bus.dst1, 32'd5);
    chk("rr dst2", bus.dst2, 32'd2);
    chk("rr dst3", bus.dst3, 32'd3);
    chk("rr dst4", bus.dst4, 32'd4);
    chk("rr dst_valid", {28'd0, bus.dst_valid}, 32'h1);
`endif

    // Random traffic; a stalled word is held until accepted.
    lastStall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!lastStall) begin
        rS   = $urandom;
        rV   = ($urandom_range(0, 3) != 0);
        rSel = 2'($urandom_range(0, 3));
      end
      rR   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rRst = ($urandom_range(0, 79) == 0);
      applyStimulus(rRst, rV, rS, rSel, rR);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
